// File: rtl/dmem_lsu_if.sv
// ============================================================================
// dmem_lsu_if : core-side request/response bus of the load/store unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface dmem_lsu_if #(
  parameter int WORD_LEN = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_wen;
  logic [2:0]          req_funct3;
  logic [WORD_LEN-1:0] req_addr;
  logic [WORD_LEN-1:0] req_wdata;
  logic                resp_valid;
  logic [WORD_LEN-1:0] resp_rdata;
  logic                resp_err;

  modport master (
    output req_valid, req_wen, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_lsu.sv
// ============================================================================
// dmem_lsu : RISC-V load/store unit in front of a word-only data memory
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_lsu #(
  parameter int WORD_LEN = 32
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  dmem_lsu_if.slave                bus,
  output logic [WORD_LEN-1:0]      addr_d,
  input  wire logic [WORD_LEN-1:0] rdata,
  output logic                     wen,
  output logic [WORD_LEN-1:0]      wdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t              r_state;
  logic [WORD_LEN-1:0] r_addr;
  logic [WORD_LEN-1:0] r_wdata;
  logic [WORD_LEN-1:0] r_rdata;
  logic [2:0]          r_funct3;
  logic                r_wen;
  logic                r_ready;
  logic                r_valid;
  logic                r_err;

  logic                w_f3_ok;
  logic                w_misal;
  logic                w_err;
  logic [4:0]          w_sh;
  logic [WORD_LEN-1:0] w_shifted;
  logic [WORD_LEN-1:0] w_load;
  logic [WORD_LEN-1:0] w_mask;
  logic [WORD_LEN-1:0] w_ins;
  logic [WORD_LEN-1:0] w_merge;

  always_comb begin
    if (bus.req_wen)
      w_f3_ok = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                (bus.req_funct3 == 3'b010);
    else
      w_f3_ok = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                (bus.req_funct3 == 3'b101);
    w_misal = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
              ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    w_err   = !w_f3_ok || w_misal;
  end

  // Lane position of the addressed byte/halfword inside the memory word.
  always_comb begin
    w_sh      = {r_addr[1:0], 3'b000};
    w_shifted = rdata >> w_sh;
    case (r_funct3)
      3'b000:  w_load = {{(WORD_LEN-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load = {{(WORD_LEN-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load = {{(WORD_LEN-8){1'b0}}, w_shifted[7:0]};
      3'b101:  w_load = {{(WORD_LEN-16){1'b0}}, w_shifted[15:0]};
      default: w_load = rdata;
    endcase
    if (r_funct3[0]) begin
      w_mask = WORD_LEN'(16'hFFFF) << w_sh;
      w_ins  = WORD_LEN'(r_wdata[15:0]) << w_sh;
    end else begin
      w_mask = WORD_LEN'(8'hFF) << w_sh;
      w_ins  = WORD_LEN'(r_wdata[7:0]) << w_sh;
    end
    w_merge = (rdata & ~w_mask) | w_ins;
  end

  // Memory-side outputs decode straight from state so reset kills a write at once.
  always_comb begin
    wen    = (r_state == S_WRITE) || ((r_state == S_DATA) && r_wen);
    wdata  = '0;
    addr_d = '0;
    if (r_state == S_WRITE)
      wdata = r_wdata;
    else if ((r_state == S_DATA) && r_wen)
      wdata = w_merge;
    if (r_state != S_IDLE)
      addr_d = {r_addr[WORD_LEN-1:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_funct3 <= '0;
      r_wen    <= 1'b0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_funct3 <= bus.req_funct3;
            r_wen    <= bus.req_wen;
            r_ready  <= 1'b0;
            if (bus.req_wen || w_err)
              r_rdata <= '0;
            if (w_err) begin
              r_state <= S_RESP;
              r_valid <= 1'b1;
              r_err   <= 1'b1;
            end else if (bus.req_wen && (bus.req_funct3 == 3'b010)) begin
              r_state <= S_WRITE;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: r_state <= S_DATA;
        S_DATA: begin
          if (!r_wen)
            r_rdata <= w_load;
          r_state <= S_RESP;
          r_valid <= 1'b1;
        end
        S_WRITE: begin
          r_state <= S_RESP;
          r_valid <= 1'b1;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_err   <= 1'b0;
          r_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu.sv
// ============================================================================
// tb_dmem_lsu : scoreboard bench for dmem_lsu with a word-wide memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_lsu;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr_d;
  logic [31:0] rdata;
  logic        wen;
  logic [31:0] wdata;

  dmem_lsu_if #(.WORD_LEN(32)) bus ();

  dmem_lsu #(.WORD_LEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .addr_d (addr_d),
    .rdata  (rdata),
    .wen    (wen),
    .wdata  (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  always @(posedge clk) begin
    if (wen) mem[addr_d[7:2]] <= wdata;
    rdata <= mem[addr_d[7:2]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nw;
    int          wlat;
    logic [31:0] wdata;
    logic [31:0] waddr;
    int          c0;
    int          wcnt0;
  } item_t;

  item_t sb[$];

  int          wcnt = 0;
  int          last_wcyc = 0;
  logic [31:0] last_wdata = '0;
  logic [31:0] last_waddr = '0;

  function automatic logic m_err(logic w, logic [2:0] f3, logic [31:0] a);
    logic ok;
    if (w) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else   ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!ok) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
    if ((f3 == 3'd2) && (a[1:0] != 2'b00)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] word, logic [31:0] a, logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*a[1:0] +: 8];
    h = word[16*a[1] +: 16];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] m_store(logic [31:0] word, logic [31:0] a, logic [2:0] f3,
                                          logic [31:0] d);
    logic [31:0] w;
    w = word;
    if (f3 == 3'd0)      w[8*a[1:0] +: 8]  = d[7:0];
    else if (f3 == 3'd1) w[16*a[1] +: 16]  = d[15:0];
    else                 w = d;
    return w;
  endfunction

  // Builds the expected response for a request accepted at the current negedge.
  task automatic push_expect(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d);
    item_t it;
    it.c0    = cyc;
    it.wcnt0 = wcnt;
    it.err   = m_err(w, f3, a);
    it.rdata = '0;
    it.nw    = 0;
    it.wlat  = 0;
    it.wdata = '0;
    it.waddr = {a[31:2], 2'b00};
    if (it.err) begin
      it.lat = 1;
    end else if (!w) begin
      it.lat   = 3;
      it.rdata = m_load(ref_mem[a[7:2]], a, f3);
    end else begin
      it.nw    = 1;
      it.lat   = (f3 == 3'd2) ? 2 : 3;
      it.wlat  = (f3 == 3'd2) ? 1 : 2;
      it.wdata = m_store(ref_mem[a[7:2]], a, f3, d);
      ref_mem[a[7:2]] = it.wdata;
    end
    sb.push_back(it);
  endtask

  always @(negedge clk) begin
    item_t it;
    if (wen) begin
      wcnt++;
      last_wcyc  = cyc;
      last_wdata = wdata;
      last_waddr = addr_d;
    end
    if (bus.resp_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_resp", 32'd1, 32'd0);
      end else begin
        it = sb.pop_front();
        chk("resp_rdata", bus.resp_rdata, it.rdata);
        chk("resp_err", {31'd0, bus.resp_err}, {31'd0, it.err});
        chk("resp_latency", cyc - it.c0, it.lat);
        chk("write_count", wcnt - it.wcnt0, it.nw);
        if (it.nw != 0) begin
          chk("write_cycle", last_wcyc - it.c0, it.wlat);
          chk("write_data", last_wdata, it.wdata);
          chk("write_addr", last_waddr, it.waddr);
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d);
    @(negedge clk);
    wait_ready();
    bus.req_valid  = 1'b1;
    bus.req_wen    = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    push_expect(w, f3, a, d);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    int prev;
    int nacc;
    int w0;
    int n;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h0101_0000 + i;
      ref_mem[i] = 32'h0101_0000 + i;
    end
    mem[4]     = 32'h8899AABB;
    ref_mem[4] = 32'h8899AABB;
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_addr_d", addr_d, 32'd0);
    chk("rst_wen", {31'd0, wen}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    rst_n = 1'b1;

    // Loads from word 0x10 = 0x8899AABB
    send(1'b0, 3'b000, 32'h11, 32'h0);
    send(1'b0, 3'b100, 32'h13, 32'h0);
    send(1'b0, 3'b001, 32'h12, 32'h0);
    send(1'b0, 3'b010, 32'h10, 32'h0);
    send(1'b0, 3'b101, 32'h10, 32'h0);

    // Read-modify-write and full-word stores
    send(1'b1, 3'b001, 32'h12, 32'hDEAD1234);
    send(1'b0, 3'b010, 32'h10, 32'h0);
    send(1'b1, 3'b000, 32'h10, 32'h00000077);
    send(1'b1, 3'b010, 32'h14, 32'hCAFEF00D);
    send(1'b0, 3'b010, 32'h10, 32'h0);
    send(1'b0, 3'b010, 32'h14, 32'h0);
    send(1'b1, 3'b000, 32'h1B, 32'h000000E5);
    send(1'b0, 3'b100, 32'h1B, 32'h0);

    // Rejected requests
    send(1'b1, 3'b010, 32'h15, 32'h12345678);
    send(1'b0, 3'b001, 32'h11, 32'h0);
    send(1'b0, 3'b011, 32'h10, 32'h0);
    send(1'b1, 3'b001, 32'h13, 32'hFFFF);
    send(1'b1, 3'b100, 32'h10, 32'hFFFF);

    // Reset during READ of an SB: nothing may reach memory or the response port
    @(negedge clk);
    wait_ready();
    w0 = wcnt;
    bus.req_valid  = 1'b1;
    bus.req_wen    = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h000000C3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rmw_read_addr", addr_d, 32'h10);
    rst_n = 1'b0;
    #1;
    chk("midrst_wen", {31'd0, wen}, 32'd0);
    chk("midrst_wdata", wdata, 32'd0);
    chk("midrst_addr_d", addr_d, 32'd0);
    chk("midrst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("midrst_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("midrst_rdata", bus.resp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_writes", wcnt - w0, 32'd0);
    chk("midrst_mem", mem[4], ref_mem[4]);

    send(1'b0, 3'b000, 32'h10, 32'h0);

    // Back-to-back LW with req_valid held high
    @(negedge clk);
    wait_ready();
    prev = -1;
    nacc = 0;
    for (int i = 0; i < 12; i++) begin
      if (i != 0) @(negedge clk);
      if (i == 11) begin
        bus.req_valid = 1'b0;
      end else begin
        bus.req_valid  = 1'b1;
        bus.req_wen    = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h14;
        if (bus.req_ready) begin
          if (prev >= 0) chk("b2b_spacing", cyc - prev, 32'd4);
          prev = cyc;
          nacc++;
          push_expect(1'b0, 3'b010, 32'h14, 32'h0);
        end
      end
    end
    chk("b2b_accepts", nacc, 32'd3);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 32'd0);

    chk("mem_word10", mem[4], 32'h1234AA77);
    chk("mem_word14", mem[5], 32'hCAFEF00D);
    chk("mem_word18", mem[6], 32'hE5010006);
    chk("mem_ref10", mem[4], ref_mem[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
